// File: rtl/uart_slave_fifo.sv
// uart_byte_fifo: generic circular byte FIFO with one extra pointer bit for full/empty.
// Latency: pushed data is visible at pop_dat on the cycle after the push.
// Backpressure: a push to a full FIFO is dropped (push_drop) unless a pop happens in the same cycle.
module uart_byte_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          push_vld,
    input  logic [DW-1:0] push_dat,
    input  logic          pop_rdy,
    output logic [DW-1:0] pop_dat,
    output logic          empty,
    output logic          full,
    output logic          push_drop
);
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [2**AW];
    logic          do_push;
    logic          do_pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop on an empty FIFO is ignored; a push on a full FIFO only lands if a pop frees the slot.
    assign do_pop    = pop_rdy & ~empty;
    assign do_push   = push_vld & (~full | do_pop);
    assign push_drop = push_vld & ~do_push;
    assign pop_dat   = mem[rd_ptr[AW-1:0]];

    // Pointer advance on accepted push/pop.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// uart_slave_fifo: bus-mapped 8N1 UART slave with RX/TX byte FIFOs, sticky errors, maskable interrupt, loopback.
// Latency: o_ack one cycle after chip select; a byte written to an idle TX starts its start bit two edges later.
// Backpressure: none on the bus; full TX FIFO drops writes (tx_drop), full RX FIFO drops received bytes (rx_overflow).
module uart_slave_fifo #(
    parameter int DATA_WIDTH    = 16,
    parameter int RX_DEPTH_LOG2 = 3,
    parameter int TX_DEPTH_LOG2 = 2,
    parameter int SYS_FREQ      = 25000000,
    parameter int BAUDRATE      = 1152000,
    parameter int DIV_WIDTH     = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_dat,
    output logic [DATA_WIDTH-1:0] o_dat,
    input  logic [1:0]            i_addr,
    input  logic                  i_we,
    input  logic                  i_cs,
    output logic                  o_ack,
    output logic                  o_int,
    input  logic                  i_uart_rx,
    output logic                  o_uart_tx
);
    localparam int                   DIV_RST   = SYS_FREQ / BAUDRATE;
    localparam logic [DIV_WIDTH-1:0] DIV_RST_V = DIV_WIDTH'(DIV_RST);
    localparam logic [DIV_WIDTH-1:0] DIV_MIN   = DIV_WIDTH'(4);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Bus / register state
    logic                  acc_held;
    logic                  fire;
    logic                  acc_wr;
    logic                  acc_rd;
    logic [3:0]            ctrl_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  div_eff;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [7:0]            status;
    logic                  rx_ovf_q;
    logic                  frame_err_q;
    logic                  tx_drop_q;

    // FIFO interfaces
    logic       tx_push;
    logic       tx_pop;
    logic [7:0] tx_head;
    logic       tx_empty;
    logic       tx_full;
    logic       tx_drop;
    logic       rx_push;
    logic       bus_pop;
    logic [7:0] rx_head;
    logic       rx_empty;
    logic       rx_full;
    logic       rx_drop;
    logic       rx_ferr;

    // TX engine
    tx_state_t            tx_state, tx_state_nxt;
    logic [DIV_WIDTH-1:0] tx_cnt, tx_cnt_nxt;
    logic [DIV_WIDTH-1:0] tx_div, tx_div_nxt;
    logic [2:0]           tx_bit, tx_bit_nxt;
    logic [7:0]           tx_sh, tx_sh_nxt;
    logic                 tx_line_nxt;
    logic                 tx_busy;
    logic                 tx_cnt_end;

    // RX engine
    rx_state_t            rx_state, rx_state_nxt;
    logic [DIV_WIDTH-1:0] rx_cnt, rx_cnt_nxt;
    logic [DIV_WIDTH-1:0] rx_div, rx_div_nxt;
    logic [2:0]           rx_bit, rx_bit_nxt;
    logic [7:0]           rx_sh, rx_sh_nxt;
    logic                 rx_in;
    logic                 rx_s1;
    logic                 rx_s2;
    logic                 rx_prev;
    logic                 rx_cnt_end;

    // An access fires once per chip-select assertion; acc_held blocks repeats while i_cs stays high.
    assign fire    = i_cs & ~o_ack & ~acc_held;
    assign acc_wr  = fire & i_we;
    assign acc_rd  = fire & ~i_we;
    assign tx_push = acc_wr && (i_addr == 2'd1);
    assign bus_pop = acc_rd && (i_addr == 2'd1);
    assign div_eff = (div_q < DIV_MIN) ? DIV_MIN : div_q;
    assign tx_busy = (tx_state != TX_IDLE);
    assign status  = {tx_busy, tx_drop_q, frame_err_q, rx_ovf_q, tx_full, tx_empty, rx_full, rx_empty};

    uart_byte_fifo #(.DW(8), .AW(TX_DEPTH_LOG2)) u_tx_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .push_vld  (tx_push),
        .push_dat  (i_dat[7:0]),
        .pop_rdy   (tx_pop),
        .pop_dat   (tx_head),
        .empty     (tx_empty),
        .full      (tx_full),
        .push_drop (tx_drop)
    );

    uart_byte_fifo #(.DW(8), .AW(RX_DEPTH_LOG2)) u_rx_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .push_vld  (rx_push),
        .push_dat  (rx_sh),
        .pop_rdy   (bus_pop),
        .pop_dat   (rx_head),
        .empty     (rx_empty),
        .full      (rx_full),
        .push_drop (rx_drop)
    );

    // Read mux: unused upper bits are zero.
    always_comb begin
        rd_val = '0;
        case (i_addr)
            2'd0: rd_val[7:0]           = status;
            2'd1: rd_val[7:0]           = rx_empty ? 8'h00 : rx_head;
            2'd2: rd_val[3:0]           = ctrl_q;
            2'd3: rd_val[DIV_WIDTH-1:0] = div_q;
            default: rd_val = '0;
        endcase
    end

    // Bus handshake, read data capture and CTRL/DIV register writes.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_ack    <= 1'b0;
            o_dat    <= '0;
            acc_held <= 1'b0;
            ctrl_q   <= '0;
            div_q    <= DIV_RST_V;
        end else begin
            o_ack    <= fire;
            acc_held <= i_cs & (acc_held | fire);
            if (fire) o_dat <= rd_val;
            if (acc_wr && (i_addr == 2'd2)) ctrl_q <= i_dat[3:0];
            if (acc_wr && (i_addr == 2'd3)) div_q  <= i_dat[DIV_WIDTH-1:0];
        end
    end

    // Sticky error flags: a set in the same cycle as a bus clear wins.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_ovf_q    <= 1'b0;
            frame_err_q <= 1'b0;
            tx_drop_q   <= 1'b0;
        end else begin
            rx_ovf_q    <= rx_drop | (rx_ovf_q    & ~(acc_wr && (i_addr == 2'd0) && i_dat[4]));
            frame_err_q <= rx_ferr | (frame_err_q & ~(acc_wr && (i_addr == 2'd0) && i_dat[5]));
            tx_drop_q   <= tx_drop | (tx_drop_q   & ~(acc_wr && (i_addr == 2'd0) && i_dat[6]));
        end
    end

    // Registered level interrupt.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) o_int <= 1'b0;
        else          o_int <= (ctrl_q[0] & ~rx_empty)
                             | (ctrl_q[1] & tx_empty & ~tx_busy)
                             | (ctrl_q[2] & (rx_ovf_q | frame_err_q | tx_drop_q));
    end

    // TX engine state register; the line is registered so it never glitches.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_div    <= DIV_MIN;
            tx_bit    <= '0;
            tx_sh     <= '0;
            o_uart_tx <= 1'b1;
        end else begin
            tx_state  <= tx_state_nxt;
            tx_cnt    <= tx_cnt_nxt;
            tx_div    <= tx_div_nxt;
            tx_bit    <= tx_bit_nxt;
            tx_sh     <= tx_sh_nxt;
            o_uart_tx <= tx_line_nxt;
        end
    end

    assign tx_cnt_end = (tx_cnt == tx_div - DIV_ONE);

    // TX next state: each state lasts tx_div cycles; divisor is latched at frame start.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_div_nxt   = tx_div;
        tx_bit_nxt   = tx_bit;
        tx_sh_nxt    = tx_sh;
        tx_line_nxt  = o_uart_tx;
        tx_pop       = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_line_nxt = 1'b1;
                if (!tx_empty) begin
                    tx_pop       = 1'b1;
                    tx_sh_nxt    = tx_head;
                    tx_div_nxt   = div_eff;
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = TX_START;
                    tx_line_nxt  = 1'b0;
                end
            end
            TX_START: begin
                tx_cnt_nxt = tx_cnt + DIV_ONE;
                if (tx_cnt_end) begin
                    tx_cnt_nxt   = '0;
                    tx_bit_nxt   = '0;
                    tx_state_nxt = TX_DATA;
                    tx_line_nxt  = tx_sh[0];
                end
            end
            TX_DATA: begin
                tx_cnt_nxt = tx_cnt + DIV_ONE;
                if (tx_cnt_end) begin
                    tx_cnt_nxt = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_nxt = TX_STOP;
                        tx_line_nxt  = 1'b1;
                    end else begin
                        tx_bit_nxt  = tx_bit + 3'd1;
                        tx_sh_nxt   = {1'b0, tx_sh[7:1]};
                        tx_line_nxt = tx_sh[1];
                    end
                end
            end
            TX_STOP: begin
                tx_cnt_nxt = tx_cnt + DIV_ONE;
                if (tx_cnt_end) begin
                    tx_cnt_nxt = '0;
                    // Back-to-back: the next start bit begins right after the stop bit.
                    if (!tx_empty) begin
                        tx_pop       = 1'b1;
                        tx_sh_nxt    = tx_head;
                        tx_div_nxt   = div_eff;
                        tx_state_nxt = TX_START;
                        tx_line_nxt  = 1'b0;
                    end else begin
                        tx_state_nxt = TX_IDLE;
                        tx_line_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                tx_state_nxt = TX_IDLE;
                tx_line_nxt  = 1'b1;
            end
        endcase
    end

    assign rx_in = ctrl_q[3] ? o_uart_tx : i_uart_rx;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_in;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // RX engine state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_div   <= DIV_MIN;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_div   <= rx_div_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_sh    <= rx_sh_nxt;
        end
    end

    assign rx_cnt_end = (rx_cnt == rx_div - DIV_ONE);

    // RX next state: confirm start at half a bit, then sample every bit period.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_div_nxt   = rx_div;
        rx_bit_nxt   = rx_bit;
        rx_sh_nxt    = rx_sh;
        rx_push      = 1'b0;
        rx_ferr      = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_s2) begin
                    rx_div_nxt   = div_eff;
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                rx_cnt_nxt = rx_cnt + DIV_ONE;
                if (rx_cnt == (rx_div >> 1) - DIV_ONE) begin
                    rx_cnt_nxt = '0;
                    rx_bit_nxt = '0;
                    // Line back high by mid start bit means it was a glitch.
                    rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                rx_cnt_nxt = rx_cnt + DIV_ONE;
                if (rx_cnt_end) begin
                    rx_cnt_nxt = '0;
                    rx_sh_nxt  = {rx_s2, rx_sh[7:1]};
                    if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
                    else                rx_bit_nxt   = rx_bit + 3'd1;
                end
            end
            RX_STOP: begin
                rx_cnt_nxt = rx_cnt + DIV_ONE;
                if (rx_cnt_end) begin
                    rx_cnt_nxt   = '0;
                    rx_push      = rx_s2;
                    rx_ferr      = ~rx_s2;
                    rx_state_nxt = RX_IDLE;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_slave_fifo.sv
// tb_uart_slave_fifo: register table, serial frame checks and randomized RX traffic against a queue model.
// Latency: checks sample one time unit after the rising clock edge.
// Backpressure: bus accesses wait for o_ack within a bounded number of cycles.
module tb_uart_slave_fifo;
    localparam int BIT   = 21;
    localparam int RXCAP = 8;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic [15:0] i_dat = '0;
    logic [15:0] o_dat;
    logic [1:0]  i_addr = '0;
    logic        i_we = 1'b0;
    logic        i_cs = 1'b0;
    logic        o_ack;
    logic        o_int;
    logic        i_uart_rx = 1'b1;
    logic        o_uart_tx;

    uart_slave_fifo #(
        .DATA_WIDTH(16), .RX_DEPTH_LOG2(3), .TX_DEPTH_LOG2(2),
        .SYS_FREQ(25000000), .BAUDRATE(1152000), .DIV_WIDTH(16)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_dat(i_dat), .o_dat(o_dat),
        .i_addr(i_addr), .i_we(i_we), .i_cs(i_cs), .o_ack(o_ack), .o_int(o_int),
        .i_uart_rx(i_uart_rx), .o_uart_tx(o_uart_tx)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural model of the receive side.
    logic [7:0] rx_q[$];
    logic       m_ovf = 1'b0;
    logic       m_ferr = 1'b0;

    typedef struct {
        logic [1:0]  addr;
        logic        we;
        logic [15:0] wdat;
        logic [15:0] exp_dat;
        logic        exp_int;
    } vec_t;
    vec_t tbl[12];

    logic [15:0] r;
    logic [15:0] r2;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic bus(input logic [1:0] a, input logic w, input logic [15:0] d, output logic [15:0] rd);
        int k;
        @(negedge i_clk);
        i_cs = 1'b1; i_addr = a; i_we = w; i_dat = d;
        k = 0;
        do begin
            @(posedge i_clk); #1; k++;
        end while (!o_ack && k < 8);
        chk("bus_ack", o_ack, 1'b1);
        rd = o_dat;
        @(negedge i_clk);
        i_cs = 1'b0; i_we = 1'b0;
    endtask

    // Status as the model sees it, valid while the transmitter is idle.
    function automatic logic [15:0] m_status();
        m_status = {8'h00, 1'b0, 1'b0, m_ferr, m_ovf, 1'b0, 1'b1,
                    rx_q.size() == RXCAP, rx_q.size() == 0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            i_uart_rx = f[i];
            repeat (BIT - 1) @(negedge i_clk);
        end
        @(negedge i_clk);
        i_uart_rx = 1'b1;
        repeat (4) @(negedge i_clk);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        send_frame(b, stop);
        if (!stop)                     m_ferr = 1'b1;
        else if (rx_q.size() == RXCAP) m_ovf  = 1'b1;
        else                           rx_q.push_back(b);
    endtask

    task automatic read_data(input string name);
        logic [15:0] d;
        logic [15:0] e;
        e = (rx_q.size() != 0) ? {8'h00, rx_q.pop_front()} : 16'h0000;
        bus(2'd1, 1'b0, 16'h0, d);
        chk(name, d, e);
    endtask

    task automatic check_status(input string name);
        logic [15:0] d;
        bus(2'd0, 1'b0, 16'h0, d);
        chk(name, d, m_status());
    endtask

    task automatic tx_check(input logic [7:0] b);
        logic [9:0] f;
        int k;
        int errs;
        f = {1'b1, b, 1'b0};
        k = 0;
        while (o_uart_tx === 1'b1 && k < 100) begin
            @(posedge i_clk); #1; k++;
        end
        chk("tx_start_low", o_uart_tx, 1'b0);
        for (int i = 0; i < 10; i++) begin
            errs = 0;
            for (int c = 0; c < BIT; c++) begin
                if (o_uart_tx !== f[i]) errs++;
                @(posedge i_clk); #1;
            end
            chk($sformatf("tx_bit%0d_bad_cycles", i), errs, 0);
        end
        chk("tx_idle_after_frame", o_uart_tx, 1'b1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acks;
        int errs;
        int k;
        logic [7:0] b;

        // Register access table, applied straight after reset (TX idle, RX empty).
        tbl[0]  = '{2'd0, 1'b0, 16'h0000, 16'h0005, 1'b0};
        tbl[1]  = '{2'd3, 1'b0, 16'h0000, 16'd21,   1'b0};
        tbl[2]  = '{2'd2, 1'b0, 16'h0000, 16'h0000, 1'b0};
        tbl[3]  = '{2'd1, 1'b0, 16'h0000, 16'h0000, 1'b0};
        tbl[4]  = '{2'd3, 1'b1, 16'd3,    16'd21,   1'b0};
        tbl[5]  = '{2'd3, 1'b0, 16'h0000, 16'd3,    1'b0};
        tbl[6]  = '{2'd3, 1'b1, 16'd21,   16'd3,    1'b0};
        tbl[7]  = '{2'd2, 1'b1, 16'h0002, 16'h0000, 1'b1};
        tbl[8]  = '{2'd2, 1'b0, 16'h0000, 16'h0002, 1'b1};
        tbl[9]  = '{2'd2, 1'b1, 16'h0004, 16'h0002, 1'b0};
        tbl[10] = '{2'd0, 1'b1, 16'h0070, 16'h0005, 1'b0};
        tbl[11] = '{2'd2, 1'b1, 16'h0000, 16'h0004, 1'b0};

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_ack", o_ack, 1'b0);
        chk("rst_dat", o_dat, 16'h0);
        chk("rst_int", o_int, 1'b0);
        chk("rst_tx",  o_uart_tx, 1'b1);
        @(negedge i_clk);
        i_reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            bus(tbl[i].addr, tbl[i].we, tbl[i].wdat, r);
            chk($sformatf("tbl%0d_dat", i), r, tbl[i].exp_dat);
            @(posedge i_clk); #1;
            chk($sformatf("tbl%0d_int", i), o_int, tbl[i].exp_int);
        end

        // Single 0x55 frame at the reset divisor, with a status read mid-frame.
        bus(2'd1, 1'b1, 16'h0055, r);
        fork
            tx_check(8'h55);
            begin
                repeat (60) @(posedge i_clk);
                bus(2'd0, 1'b0, 16'h0, r2);
                chk("status_mid_frame", r2, 16'h0085);
            end
        join
        repeat (3) @(posedge i_clk);
        // TX fields read 0x04 (empty, idle); rx_empty adds bit 0.
        check_status("status_after_frame");

        // Loopback: three bytes come back in order.
        bus(2'd2, 1'b1, 16'h0009, r);
        bus(2'd1, 1'b1, 16'h0000, r);
        bus(2'd1, 1'b1, 16'h00FF, r);
        bus(2'd1, 1'b1, 16'h00A5, r);
        chk("lb_int_before", o_int, 1'b0);
        repeat (30 * BIT + 60) @(posedge i_clk);
        #1;
        rx_q.push_back(8'h00); rx_q.push_back(8'hFF); rx_q.push_back(8'hA5);
        chk("lb_int_pending", o_int, 1'b1);
        read_data("lb_byte0");
        read_data("lb_byte1");
        read_data("lb_byte2");
        check_status("lb_status_empty");
        chk("lb_int_cleared", o_int, 1'b0);
        bus(2'd2, 1'b1, 16'h0000, r);

        // Bad stop bit, then a short glitch.
        rx_frame(8'h3C, 1'b0);
        check_status("ferr_status");
        bus(2'd0, 1'b1, 16'h0020, r);
        m_ferr = 1'b0;
        check_status("ferr_cleared");
        @(negedge i_clk);
        i_uart_rx = 1'b0;
        repeat (5) @(negedge i_clk);
        i_uart_rx = 1'b1;
        repeat (300) @(negedge i_clk);
        check_status("glitch_no_flags");
        read_data("glitch_nothing_pushed");

        // Overflow: nine good frames into an 8-deep FIFO, frame error also pending.
        rx_frame(8'h81, 1'b0);
        for (int i = 0; i < 9; i++) rx_frame(8'($urandom), 1'b1);
        check_status("ovf_status");
        bus(2'd0, 1'b1, 16'h0010, r);
        m_ovf = 1'b0;
        check_status("ovf_clear_only");
        for (int i = 0; i < RXCAP; i++) read_data($sformatf("ovf_byte%0d", i));
        read_data("ovf_empty_read");
        bus(2'd0, 1'b1, 16'h0070, r);
        m_ferr = 1'b0;

        // Randomized traffic: frames with occasional bad stop bits and interleaved reads.
        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 2) != 0) rx_frame(8'($urandom), $urandom_range(0, 7) != 0);
            else                           read_data($sformatf("rand_read%0d", i));
        end
        check_status("rand_status");
        k = rx_q.size();
        for (int i = 0; i < k; i++) read_data($sformatf("rand_drain%0d", i));
        bus(2'd0, 1'b1, 16'h0070, r);
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
        check_status("rand_flags_cleared");

        // One DATA read with chip select held five cycles.
        rx_frame(8'($urandom), 1'b1);
        rx_frame(8'($urandom), 1'b1);
        @(negedge i_clk);
        i_cs = 1'b1; i_addr = 2'd1; i_we = 1'b0;
        acks = 0;
        r = '0;
        for (int c = 0; c < 5; c++) begin
            @(posedge i_clk); #1;
            if (o_ack) begin
                acks++;
                r = o_dat;
            end
        end
        @(negedge i_clk);
        i_cs = 1'b0;
        chk("hold_cs_ack_count", acks, 1);
        b = rx_q.pop_front();
        chk("hold_cs_data", r, {8'h00, b});
        read_data("hold_cs_second_byte");
        check_status("hold_cs_empty");

        // TX FIFO overrun while the engine is busy with a slow frame.
        bus(2'd3, 1'b1, 16'd30, r);
        for (int i = 0; i < 6; i++) bus(2'd1, 1'b1, 16'(i + 1), r);
        bus(2'd0, 1'b0, 16'h0, r);
        chk("tx_drop_status", r, 16'h00C9);

        // Reset in the middle of a frame, while the line is low.
        k = 0;
        while (o_uart_tx === 1'b1 && k < 400) begin
            @(posedge i_clk); #1; k++;
        end
        chk("tx_low_before_reset", o_uart_tx, 1'b0);
        i_reset = 1'b0;
        #1;
        chk("midrst_tx_high", o_uart_tx, 1'b1);
        chk("midrst_ack", o_ack, 1'b0);
        chk("midrst_int", o_int, 1'b0);
        repeat (2) @(negedge i_clk);
        i_reset = 1'b1;
        bus(2'd0, 1'b0, 16'h0, r);
        chk("midrst_status", r, 16'h0005);
        bus(2'd3, 1'b0, 16'h0, r);
        chk("midrst_div", r, 16'd21);
        errs = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge i_clk); #1;
            if (o_uart_tx !== 1'b1) errs++;
        end
        chk("midrst_line_idle", errs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_slave_fifo.md
Name: uart_slave_fifo

Overview:
- Parametrised successor of the combined UART master/slave bridge: a stand-alone, bus-mapped UART slave.
- Contains its own TX/RX shift engines, configurable-depth RX and TX byte FIFOs and a programmable baud divisor.
- Adds sticky error flags, a maskable interrupt and an internal loopback mode.
- Sits on the CPU data bus beside the protocol master; drives one TX line and receives one RX line.

Parameters:
- DATA_WIDTH, 16: bus data width, must be >= DIV_WIDTH and >= 8.
- RX_DEPTH_LOG2, 3: RX FIFO holds 2^RX_DEPTH_LOG2 bytes.
- TX_DEPTH_LOG2, 2: TX FIFO holds 2^TX_DEPTH_LOG2 bytes.
- SYS_FREQ, 25000000: clock frequency in Hz.
- BAUDRATE, 1152000: reset baud rate.
- DIV_WIDTH, 16: baud divisor register width.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_dat  in  DATA_WIDTH  bus write data.
- o_dat  out  DATA_WIDTH  registered bus read data.
- i_addr  in  2  register select.
- i_we  in  1  write strobe, qualified by i_cs.
- i_cs  in  1  chip select, held until o_ack.
- o_ack  out  1  one-cycle access acknowledge.
- o_int  out  1  level interrupt.
- i_uart_rx  in  1  serial input, asynchronous.
- o_uart_tx  out  1  serial output, idles high.

Behaviour:
- Reset (i_reset low, async):
  - o_ack=0, o_dat=0, o_int=0, o_uart_tx=1.
  - FIFOs empty; sticky flags 0; ctrl=0.
  - divisor=SYS_FREQ/BAUDRATE.
  - TX/RX engines return to IDLE immediately. A frame in progress is abandoned and the line goes high in the same cycle.
- Bus access:
  - An access fires on the edge where i_cs && ~o_ack. On that edge: o_ack<=1, o_dat<=register value, and the side effect executes.
  - The next edge clears o_ack. Exactly one side effect occurs per access regardless of how long i_cs is held.
  - Unused upper o_dat bits read 0.
- Register map:
  - Address 0, STATUS (read):
    - [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full.
    - [4] rx_overflow (sticky), [5] frame_err (sticky), [6] tx_drop (sticky), [7] tx_busy.
    - Write: a 1 in bit 4, 5 or 6 clears that flag; other bits are ignored.
  - Address 1, DATA:
    - Read returns the RX head byte and pops it. Reading an empty FIFO returns 0 and does not pop.
    - Write pushes i_dat[7:0] to the TX FIFO. If the FIFO is full the byte is dropped and tx_drop is set.
  - Address 2, CTRL (read/write):
    - [0] ie_rx: RX FIFO non-empty.
    - [1] ie_tx: TX FIFO empty and engine idle.
    - [2] ie_err: any sticky flag set.
    - [3] loopback.
  - Address 3, DIV (read/write): bit period in clocks. Values <4 are stored but the engines use 4. A new value takes effect at the next frame start.
- Interrupt: o_int is registered: o_int <= (ie_rx & ~rx_empty) | (ie_tx & tx_empty & ~tx_busy) | (ie_err & |sticky).
- TX engine (IDLE, START, DATA, STOP):
  - In IDLE, if the TX FIFO is non-empty: pop and latch the byte, then go to START.
  - Each state lasts div cycles. Frame is 8N1, LSB first.
  - STOP returns to IDLE. A back-to-back byte starts on the cycle after STOP ends, with no extra idle.
  - tx_busy = state != IDLE.
- RX engine:
  - Input: i_uart_rx, or o_uart_tx when loopback=1. In loopback the external o_uart_tx still toggles. The input passes through a 2-FF synchroniser.
  - IDLE→START on a falling edge.
  - At div/2 the start bit must still be low; if high, return to IDLE (glitch).
  - Sample 8 data bits at div intervals, then the stop bit:
    - stop=0: set frame_err, drop the byte.
    - stop=1: push the byte. If the RX FIFO is full, drop the byte and set rx_overflow.
  - Return to IDLE after the stop sample.
- FIFOs:
  - Circular buffers with DEPTH_LOG2+1-bit pointers.
  - A simultaneous push and pop on a full FIFO is legal: both occur and the count is unchanged.
  - A simultaneous push and pop on an empty FIFO: the push occurs, the pop is ignored.
  - Bus pop and engine push can coincide; same rule applies.
- Sticky flags: a flag set and a bus clear in the same cycle leaves the flag set.

Test Plan:
- Reset with div=21: write DATA=0x55 → o_uart_tx low for 21 clk, then 1,0,1,0,1,0,1,0 at 21 clk each, then high. STATUS reads tx_busy=1 mid-frame and 0x04 after.
- Loopback=1, write 0x00,0xFF,0xA5 → RX FIFO returns 0x00,0xFF,0xA5 in order; rx_empty=1 after the third read; o_int follows ie_rx.
- Drive 9 frames into i_uart_rx with RX_DEPTH_LOG2=3 and no reads → rx_full=1, rx_overflow=1, first 8 bytes intact. STATUS write 0x10 clears rx_overflow only.
- Frame with stop bit=0 → frame_err=1, nothing pushed. A 0.25-bit low glitch on i_uart_rx → nothing pushed, no flags.
- Fill the TX FIFO plus one extra write while TX is stalled → tx_drop=1. Assert i_reset mid-frame → o_uart_tx=1 immediately, STATUS=0x05, div=SYS_FREQ/BAUDRATE.
- Hold i_cs 5 cycles on a DATA read → exactly one pop, o_ack high for exactly one cycle.
